// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter: ALU priority, load-return FIFO, bypass and busy flags
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [AW-1:0]              alu_rd,
    input  logic [DW-1:0]              alu_data,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [AW-1:0]              ld_rd,
    input  logic [DW-1:0]              ld_data,
    output logic [AW-1:0]              a3,
    output logic [DW-1:0]              wd3,
    output logic                       we3,
    input  logic [AW-1:0]              rs_addr,
    input  logic [AW-1:0]              rt_addr,
    output logic                       rs_fwd,
    output logic                       rt_fwd,
    output logic [DW-1:0]              rs_fwd_data,
    output logic [DW-1:0]              rt_fwd_data,
    output logic                       rs_busy,
    output logic                       rt_busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] rd_q   [DEPTH];
    logic [AW-1:0] rd_d   [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          we3_q, we3_d;
    logic          push, pop;
    logic [PW-1:0] wr_idx, rd_idx;

    assign wr_idx   = wr_ptr_q[PW-1:0];
    assign rd_idx   = rd_ptr_q[PW-1:0];
    assign ld_ready = (count_q < CW'(DEPTH));
    assign push     = ld_valid && ld_ready;
    assign pop      = !alu_valid && (count_q != '0);

    always_comb begin
        rd_d     = rd_q;
        data_d   = data_q;
        live_d   = live_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        we3_d    = 1'b0;
        if (alu_valid) begin
            a3_d  = alu_rd;
            wd3_d = alu_data;
            we3_d = (alu_rd != '0);
        end else if (pop) begin
            a3_d  = rd_q[rd_idx];
            wd3_d = data_q[rd_idx];
            we3_d = live_q[rd_idx] && (rd_q[rd_idx] != '0);
            live_d[rd_idx] = 1'b0;
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (push) begin
            rd_d[wr_idx]   = ld_rd;
            data_d[wr_idx] = ld_data;
            live_d[wr_idx] = 1'b1;
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
        // WAW kill runs after the push so a same-edge load counts as older than the ALU write
        if (alu_valid && (alu_rd != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_d[i] == alu_rd) live_d[i] = 1'b0;
            end
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a3_q     <= '0;
            wd3_q    <= '0;
            we3_q    <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            data_q   <= data_d;
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            we3_q    <= we3_d;
        end
    end

    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && rd_q[i] == rs_addr) rs_busy = 1'b1;
            if (live_q[i] && rd_q[i] == rt_addr) rt_busy = 1'b1;
        end
        if (rs_addr == '0) rs_busy = 1'b0;
        if (rt_addr == '0) rt_busy = 1'b0;
    end

    assign a3          = a3_q;
    assign wd3         = wd3_q;
    assign we3         = we3_q;
    assign rs_fwd      = we3_q && (a3_q == rs_addr) && (rs_addr != '0);
    assign rt_fwd      = we3_q && (a3_q == rt_addr) && (rt_addr != '0);
    assign rs_fwd_data = wd3_q;
    assign rt_fwd_data = wd3_q;
    assign fifo_count  = count_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter against a queue-based reference model
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0, ld_valid = 1'b0;
    logic [4:0]  alu_rd = '0, ld_rd = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] alu_data = '0, ld_data = '0;
    logic        ld_ready, we3, rs_fwd, rt_fwd, rs_busy, rt_busy;
    logic [4:0]  a3;
    logic [31:0] wd3, rs_fwd_data, rt_fwd_data;
    logic [2:0]  fifo_count;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .a3(a3), .wd3(wd3), .we3(we3),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
        .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
        .rs_busy(rs_busy), .rt_busy(rt_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        live;
    } ld_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        int          count;
        logic        rsb, rtb, rsf, rtf;
    } exp_t;

    ld_t         mq[$];
    exp_t        sb[$];
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd3 = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_busy(input logic [4:0] addr);
        if (addr == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].live && mq[i].rd == addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t mk_exp(input logic we, input logic [4:0] rs, input logic [4:0] rt);
        exp_t e;
        e.we    = we;
        e.a3    = m_a3;
        e.wd3   = m_wd3;
        e.count = mq.size();
        e.rsb   = m_busy(rs);
        e.rtb   = m_busy(rt);
        e.rsf   = we && m_a3 == rs && rs != 5'd0;
        e.rtf   = we && m_a3 == rt && rt != 5'd0;
        return e;
    endfunction

    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic [4:0] rs, input logic [4:0] rt);
        logic we;
        logic do_push;
        ld_t  h;
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        ld_valid = lv;  ld_rd = lrd;  ld_data = ldd;
        rs_addr = rs;   rt_addr = rt;
        do_push = lv && (mq.size() < DEPTH);
        we = 1'b0;
        if (av) begin
            m_a3 = ard; m_wd3 = ad; we = (ard != 5'd0);
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_a3 = h.rd; m_wd3 = h.data; we = h.live && (h.rd != 5'd0);
        end
        if (do_push) mq.push_back('{rd: lrd, data: ldd, live: 1'b1});
        if (av && ard != 5'd0) foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
        sb.push_back(mk_exp(we, rs, rt));
    endtask

    task automatic idle(input int n, input logic [4:0] rs);
        repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, rs, 5'd0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("rst_async_we3", 64'(we3), 64'd0);
        chk("rst_async_count", 64'(fifo_count), 64'd0);
        chk("rst_async_ready", 64'(ld_ready), 64'd1);
        mq.delete();
        m_a3 = '0; m_wd3 = '0;
        sb.push_back(mk_exp(1'b0, rs_addr, rt_addr));
        repeat (n - 1) begin
            @(negedge clk);
            sb.push_back(mk_exp(1'b0, rs_addr, rt_addr));
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("we3", 64'(we3), 64'(e.we));
                chk("a3", 64'(a3), 64'(e.a3));
                chk("wd3", 64'(wd3), 64'(e.wd3));
                chk("fifo_count", 64'(fifo_count), 64'(e.count));
                chk("ld_ready", 64'(ld_ready), 64'(e.count < DEPTH));
                chk("rs_busy", 64'(rs_busy), 64'(e.rsb));
                chk("rt_busy", 64'(rt_busy), 64'(e.rtb));
                chk("rs_fwd", 64'(rs_fwd), 64'(e.rsf));
                chk("rt_fwd", 64'(rt_fwd), 64'(e.rtf));
                chk("rs_fwd_data", 64'(rs_fwd_data), 64'(e.wd3));
                chk("rt_fwd_data", 64'(rt_fwd_data), 64'(e.wd3));
            end
        end
    end

    initial begin : driver
        int phase;
        do_reset(3);
        // T1: ALU write then bypass
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(1, 5'd5);
        // T2: writes to $0
        step(1'b1, 5'd0, 32'd1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd9, 5'd0, 5'd0);
        idle(2, 5'd0);
        // T3: fill under ALU pressure, overflow attempt, then drain
        for (int i = 1; i <= 4; i++)
            step(1'b1, 5'd9, 32'(i), 1'b1, 5'(i), 32'(11 * i), 5'(i), 5'd9);
        step(1'b1, 5'd9, 32'd5, 1'b1, 5'd6, 32'd66, 5'd6, 5'd1);
        idle(5, 5'd3);
        // T4: WAW kill
        step(1'b1, 5'd3, 32'd0, 1'b1, 5'd7, 32'd1, 5'd7, 5'd7);
        step(1'b1, 5'd7, 32'd2, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
        idle(2, 5'd7);
        // T5: push+pop at count=3 across pointer wrap
        for (int i = 1; i <= 3; i++)
            step(1'b1, 5'd10, 32'd0, 1'b1, 5'(i), 32'(100 + i), 5'd2, 5'd3);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'd104, 5'd4, 5'd1);
        idle(5, 5'd4);
        // T6: reset mid-drain
        for (int i = 1; i <= 3; i++)
            step(1'b1, 5'd11, 32'd0, 1'b1, 5'(i), 32'(200 + i), 5'd1, 5'd2);
        idle(1, 5'd2);
        do_reset(2);
        idle(3, 5'd2);
        // randomized traffic with phases of heavy and light ALU load
        for (int k = 0; k < 600; k++) begin
            phase = (k / 40) % 3;
            step(($urandom_range(0, 9) < (phase == 0 ? 9 : (phase == 1 ? 5 : 1))),
                 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            if (k == 300) do_reset(2);
        end
        idle(8, 5'd0);
        @(posedge clk);
        #2;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
